spram_arb2: RTL and testbench

- Parametrised single-port synchronous RAM shared by two requesters: channel A (CPU/`spif` side) and channel B (DMA/hardware I/O).
- Adds byte-lane write enables, a read enable that is honoured, per-channel read-valid strobes, and an arbiter that produces a hold signal for the losing channel.
- A bounded-wait counter guarantees forward progress for channel A.
- Intended as a drop-in data/code RAM behind the CPU, with DMA hold-off.

---
 rtl/spram_arb2_if.sv | 40 ++++
 rtl/spram_arb2.sv | 126 ++++++++++++
 tb/tb_spram_arb2.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/spram_arb2_if.sv
// Bus bundle for spram_arb2: two requester channels (A = CPU side, B = DMA side).
// The slave modport is the RAM/arbiter; the master modport is the requester side.
interface spram_arb2_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_din;
    logic [BE_WIDTH-1:0]   a_be;
    logic                  a_we;
    logic                  a_re;
    logic                  a_hold;
    logic [DATA_WIDTH-1:0] a_dout;
    logic                  a_rvalid;

    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_din;
    logic [BE_WIDTH-1:0]   b_be;
    logic                  b_we;
    logic                  b_re;
    logic                  b_hold;
    logic [DATA_WIDTH-1:0] b_dout;
    logic                  b_rvalid;

    modport master (
        output a_addr, a_din, a_be, a_we, a_re,
        input  a_hold, a_dout, a_rvalid,
        output b_addr, b_din, b_be, b_we, b_re,
        input  b_hold, b_dout, b_rvalid
    );

    modport slave (
        input  a_addr, a_din, a_be, a_we, a_re,
        output a_hold, a_dout, a_rvalid,
        input  b_addr, b_din, b_be, b_we, b_re,
        output b_hold, b_dout, b_rvalid
    );
endinterface

// File: rtl/spram_arb2.sv
// Single-port RAM shared by channel A (CPU) and channel B (DMA), B-priority with bounded A wait.
// Define SPRAM_ARB_RR_EN to replace fixed priority with round-robin on contention.
module spram_arb2 #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 7
) (
    input  logic        clk,
    input  logic        rst,
    spram_arb2_if.slave bus
);
    localparam int         NB       = DATA_WIDTH / 8;
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
            $error("spram_arb2: DATA_WIDTH must be a non-zero multiple of 8");
        end
        if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
            $error("spram_arb2: MAX_WAIT must be in 1..255");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic                  a_req, b_req;
    logic                  grant_a, grant_b;
    logic                  force_a;
    logic [7:0]            wait_cnt;

    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_din;
    logic [NB-1:0]         acc_be;
    logic                  acc_we;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [DATA_WIDTH-1:0] a_dout_q, b_dout_q;
    logic                  a_rvalid_q, b_rvalid_q;

    assign a_req   = bus.a_we | bus.a_re;
    assign b_req   = bus.b_we | bus.b_re;
    assign force_a = (wait_cnt == WAIT_MAX);

`ifdef SPRAM_ARB_RR_EN
    localparam logic [0:0] CH_A = 1'b0;
    localparam logic [0:0] CH_B = 1'b1;

    logic [0:0] rr_last;

    // On contention the channel that lost the previous contended cycle wins.
    always_comb begin
        grant_a = a_req & (~b_req | (rr_last == CH_B) | force_a);
        grant_b = b_req & ~grant_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= CH_B;
        end else if (a_req && b_req) begin
            rr_last <= grant_a ? CH_A : CH_B;
        end
    end
`else
    always_comb begin
        grant_a = a_req & (~b_req | force_a);
        grant_b = b_req & ~grant_a;
    end
`endif

    assign bus.a_hold = a_req & ~grant_a;
    assign bus.b_hold = b_req & ~grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (a_req && !grant_a) begin
            wait_cnt <= force_a ? wait_cnt : wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // The single physical port is steered to whichever channel holds the grant.
    always_comb begin
        acc_addr = grant_a ? bus.a_addr : bus.b_addr;
        acc_din  = grant_a ? bus.a_din  : bus.b_din;
        acc_be   = grant_a ? bus.a_be   : bus.b_be;
        acc_we   = (grant_a & bus.a_we) | (grant_b & bus.b_we);
    end

    assign rd_data = mem[acc_addr];

    always_ff @(posedge clk) begin
        if (!rst && acc_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (acc_be[i]) begin
                    mem[acc_addr][8*i +: 8] <= acc_din[8*i +: 8];
                end
            end
        end
    end

    // Read data is sampled before the same-edge write lands, giving read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_dout_q   <= '0;
            b_dout_q   <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= grant_a & bus.a_re;
            b_rvalid_q <= grant_b & bus.b_re;
            if (grant_a && bus.a_re) begin
                a_dout_q <= rd_data;
            end
            if (grant_b && bus.b_re) begin
                b_dout_q <= rd_data;
            end
        end
    end

    assign bus.a_dout   = a_dout_q;
    assign bus.b_dout   = b_dout_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
endmodule

// File: tb/tb_spram_arb2.sv
// Self-checking bench for spram_arb2: directed vector table, contention run, randomized run
// against a behavioural model of the arbitration and memory rules.
module tb_spram_arb2;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MAX_WAIT = 7;

    typedef struct {
        bit          rst;
        bit          aw;
        bit          ar;
        logic [9:0]  aa;
        logic [15:0] ad;
        logic [1:0]  abe;
        bit          bw;
        bit          br;
        logic [9:0]  ba;
        logic [15:0] bd;
        logic [1:0]  bbe;
        bit          eah;
        bit          ebh;
        bit          earv;
        logic [15:0] ead;
        bit          ebrv;
        logic [15:0] ebd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    spram_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    spram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [15:0] m_mem [1024];
    logic [15:0] m_ad, m_bd;
    bit          m_arv, m_brv;
    int          m_streak;
    bit          m_last_a;
    bit          m_ah, m_bh;

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                          input logic [1:0] be);
        logic [15:0] mask;
        mask = {{8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (din & mask);
    endfunction

    // One clock cycle: drive at negedge, check holds, let the edge happen, check outputs.
    task automatic apply(input vec_t v, input bit use_tbl, output bit a_held);
        bit areq, breq, ga, gb;
        @(negedge clk);
        rst        = v.rst;
        bus.a_we   = v.aw;  bus.a_re = v.ar;  bus.a_addr = v.aa;
        bus.a_din  = v.ad;  bus.a_be = v.abe;
        bus.b_we   = v.bw;  bus.b_re = v.br;  bus.b_addr = v.ba;
        bus.b_din  = v.bd;  bus.b_be = v.bbe;
        #1;
        areq = v.aw | v.ar;
        breq = v.bw | v.br;
`ifdef SPRAM_ARB_RR_EN
        ga = (areq && breq) ? !m_last_a : areq;
`else
        ga = (areq && breq) ? (m_streak >= MAX_WAIT) : areq;
`endif
        gb = breq && !ga;
        a_held = bus.a_hold;
        chk1("a_hold", bus.a_hold, use_tbl ? v.eah : (areq && !ga));
        chk1("b_hold", bus.b_hold, use_tbl ? v.ebh : (breq && !gb));
        if (v.rst) begin
            m_ad = '0; m_bd = '0; m_arv = 0; m_brv = 0;
            m_streak = 0; m_last_a = 0; m_ah = 0; m_bh = 0;
        end else begin
            m_ah  = areq && !ga;
            m_bh  = breq && !gb;
            m_arv = ga && v.ar;
            m_brv = gb && v.br;
            if (m_arv) m_ad = m_mem[v.aa];
            if (m_brv) m_bd = m_mem[v.ba];
            if (ga && v.aw) m_mem[v.aa] = merge(m_mem[v.aa], v.ad, v.abe);
            if (gb && v.bw) m_mem[v.ba] = merge(m_mem[v.ba], v.bd, v.bbe);
            m_streak = m_ah ? ((m_streak + 1 > MAX_WAIT) ? MAX_WAIT : m_streak + 1) : 0;
            if (areq && breq) m_last_a = ga;
        end
        @(posedge clk);
        #1;
        chk1 ("a_rvalid", bus.a_rvalid, use_tbl ? v.earv : m_arv);
        chk16("a_dout",   bus.a_dout,   use_tbl ? v.ead  : m_ad);
        chk1 ("b_rvalid", bus.b_rvalid, use_tbl ? v.ebrv : m_brv);
        chk16("b_dout",   bus.b_dout,   use_tbl ? v.ebd  : m_bd);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t cur;
        bit   held;
        int   a_grants;

        rst = 1'b1;
        bus.a_we = 0; bus.a_re = 0; bus.a_addr = '0; bus.a_din = '0; bus.a_be = '0;
        bus.b_we = 0; bus.b_re = 0; bus.b_addr = '0; bus.b_din = '0; bus.b_be = '0;

        //            rst aw ar aa  ad        abe bw br ba  bd        bbe eah ebh earv ead       ebrv ebd
        tbl.push_back('{1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  16'h0000, 0, 16'h0000});
        tbl.push_back('{0, 1, 0, 5, 16'hBEEF, 3, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  16'h0000, 0, 16'h0000});
        tbl.push_back('{0, 0, 1, 5, 16'h0000, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  1,  16'hBEEF, 0, 16'h0000});
        tbl.push_back('{0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  16'hBEEF, 0, 16'h0000});
        tbl.push_back('{0, 1, 0, 3, 16'h1234, 3, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  16'hBEEF, 0, 16'h0000});
        tbl.push_back('{0, 1, 0, 3, 16'hAB55, 1, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  16'hBEEF, 0, 16'h0000});
        tbl.push_back('{0, 0, 1, 3, 16'h0000, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  1,  16'h1255, 0, 16'h0000});
`ifdef SPRAM_ARB_RR_EN
        tbl.push_back('{0, 0, 1, 3, 16'h0000, 0, 1, 0, 9, 16'h7777, 3,  0,  1,  1,  16'h1255, 0, 16'h0000});
        tbl.push_back('{0, 0, 0, 0, 16'h0000, 0, 1, 0, 9, 16'h7777, 3,  0,  0,  0,  16'h1255, 0, 16'h0000});
`else
        tbl.push_back('{0, 0, 1, 3, 16'h0000, 0, 1, 0, 9, 16'h7777, 3,  1,  0,  0,  16'h1255, 0, 16'h0000});
        tbl.push_back('{0, 0, 1, 3, 16'h0000, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  1,  16'h1255, 0, 16'h0000});
`endif
        tbl.push_back('{0, 1, 1, 9, 16'h0001, 3, 0, 0, 0, 16'h0000, 0,  0,  0,  1,  16'h7777, 0, 16'h0000});
        tbl.push_back('{0, 0, 1, 9, 16'h0000, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  1,  16'h0001, 0, 16'h0000});
        tbl.push_back('{0, 0, 0, 0, 16'h0000, 0, 0, 1, 9, 16'h0000, 0,  0,  0,  0,  16'h0001, 1, 16'h0001});
        tbl.push_back('{1, 0, 0, 0, 16'h0000, 0, 1, 0, 9, 16'hFFFF, 3,  0,  0,  0,  16'h0000, 0, 16'h0000});
        tbl.push_back('{0, 0, 0, 0, 16'h0000, 0, 0, 1, 9, 16'h0000, 0,  0,  0,  0,  16'h0000, 1, 16'h0001});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], 1'b1, held);
        end

        // Sustained contention straight after reset: count A grants over 24 cycles.
        cur = '{1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000};
        apply(cur, 1'b0, held);
        cur = '{0, 0, 1, 5, 16'h0000, 0, 1, 0, 20, 16'h5A5A, 3, 0, 0, 0, 16'h0000, 0, 16'h0000};
        a_grants = 0;
        for (int i = 0; i < 24; i++) begin
            apply(cur, 1'b0, held);
            if (!held) a_grants++;
        end
        n_vec++;
`ifdef SPRAM_ARB_RR_EN
        if (a_grants != 12) begin
            n_bad++;
            $display("FAIL a_grant_count: got %0d expected %0d", a_grants, 12);
        end
`else
        if (a_grants != 3) begin
            n_bad++;
            $display("FAIL a_grant_count: got %0d expected %0d", a_grants, 3);
        end
`endif

        // Fill addresses 0..15 with known contents for the randomized phase.
        for (int i = 0; i < 16; i++) begin
            cur = '{0, 1, 0, 10'(i), 16'($urandom), 3, 0, 0, 0, 16'h0000, 0,
                    0, 0, 0, 16'h0000, 0, 16'h0000};
            apply(cur, 1'b0, held);
        end

        // Held channels keep their request stable; reset drops holds.
        for (int i = 0; i < 400; i++) begin
            cur.rst = ($urandom_range(0, 63) == 0);
            if (!m_ah) begin
                cur.aw  = 1'($urandom_range(0, 1));
                cur.ar  = 1'($urandom_range(0, 1));
                cur.aa  = 10'($urandom_range(0, 15));
                cur.ad  = 16'($urandom);
                cur.abe = 2'($urandom_range(0, 3));
            end
            if (!m_bh) begin
                cur.bw  = 1'($urandom_range(0, 1));
                cur.br  = 1'($urandom_range(0, 1));
                cur.ba  = 10'($urandom_range(0, 15));
                cur.bd  = 16'($urandom);
                cur.bbe = 2'($urandom_range(0, 3));
            end
            apply(cur, 1'b0, held);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
